// File: rtl/sample_capture_gate.sv
// Capture gate feeding the sample-file writer: arm on start, wait for a trigger, forward decimated narrowed samples.
// Optional feature: define CAPTURE_ROUND_EN for round-to-nearest with saturation instead of floor truncation.
module sample_capture_gate #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned OUT_WIDTH   = 10,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   trig,
  input  logic [CNT_WIDTH-1:0]   cfg_len,
  input  logic [DECIM_WIDTH-1:0] cfg_decim,
  input  logic                   din_valid,
  input  logic [IN_WIDTH-1:0]    din,
  output logic                   enable,
  output logic [OUT_WIDTH-1:0]   signal_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int unsigned SH = IN_WIDTH - OUT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DECIM_WIDTH-1:0] decim_q, decim_d;
  logic [DECIM_WIDTH-1:0] phase_q, phase_d;
  logic [OUT_WIDTH-1:0]   sample_q, sample_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sat_q, sat_d;

  logic [OUT_WIDTH-1:0]   narrow_c;
  logic                   narrow_sat_c;

`ifdef CAPTURE_ROUND_EN
  localparam logic [IN_WIDTH:0] RND_HALF = (IN_WIDTH+1)'(1) << (SH-1);

  logic [IN_WIDTH:0]  rnd_sum;
  logic [OUT_WIDTH:0] rnd_shr;

  // Round half up in one extra bit, then clamp when the kept top bits disagree.
  always_comb begin
    rnd_sum      = {din[IN_WIDTH-1], din} + RND_HALF;
    rnd_shr      = (OUT_WIDTH+1)'(rnd_sum >> SH);
    narrow_sat_c = rnd_shr[OUT_WIDTH] != rnd_shr[OUT_WIDTH-1];
    if (narrow_sat_c) begin
      narrow_c = {rnd_shr[OUT_WIDTH], {(OUT_WIDTH-1){~rnd_shr[OUT_WIDTH]}}};
    end else begin
      narrow_c = rnd_shr[OUT_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    narrow_c     = OUT_WIDTH'(din >> SH);
    narrow_sat_c = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      decim_q  <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      decim_q  <= decim_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
    end
  end

  logic                   emit;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [DECIM_WIDTH-1:0] phase_nxt;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    decim_d   = decim_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    sat_d     = sat_q;
    enable_d  = 1'b0;
    done_d    = (state_q == S_DONE);
    emit      = 1'b0;
    cnt_inc   = cnt_q + CNT_WIDTH'(1);
    phase_nxt = (phase_q == decim_q) ? '0 : phase_q + DECIM_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          decim_d = cfg_decim;
          sat_d   = 1'b0;
          cnt_d   = '0;
          phase_d = '0;
          state_d = (cfg_len == '0) ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        // The trigger sample occupies phase 0, so decimation counts on from it.
        if (din_valid && trig) begin
          emit    = 1'b1;
          cnt_d   = CNT_WIDTH'(1);
          phase_d = (decim_q == '0) ? '0 : DECIM_WIDTH'(1);
          state_d = (len_q == CNT_WIDTH'(1)) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (din_valid) begin
          phase_d = phase_nxt;
          if (phase_q == '0) begin
            emit  = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      enable_d = 1'b1;
      sample_d = narrow_c;
      if (narrow_sat_c) begin
        sat_d = 1'b1;
      end
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
  end

  assign enable     = enable_q;
  assign signal_out = sample_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_sample_capture_gate.sv
// Self-checking bench for sample_capture_gate; expectations come from a sample-selection model over logged stimulus.
// Build with CAPTURE_ROUND_EN defined to check the rounding/saturation variant.
module tb_sample_capture_gate;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEC_W = 8;
  localparam int          STEP  = 2 ** (IN_W - OUT_W);
  localparam int          OMAX  = 2 ** (OUT_W - 1) - 1;
  localparam int          OMIN  = -(2 ** (OUT_W - 1));

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              trig;
  logic [CNT_W-1:0]  cfg_len;
  logic [DEC_W-1:0]  cfg_decim;
  logic              din_valid;
  logic [IN_W-1:0]   din;
  logic              enable;
  logic [OUT_W-1:0]  signal_out;
  logic              busy;
  logic              done;
  logic              sat_flag;

  int checks   = 0;
  int failures = 0;
  int last_out = 0;

  always #5 clk = ~clk;

  sample_capture_gate #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W), .DECIM_WIDTH(DEC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .trig(trig), .cfg_len(cfg_len),
    .cfg_decim(cfg_decim), .din_valid(din_valid), .din(din), .enable(enable),
    .signal_out(signal_out), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int narrow_ref(input int x, output bit sat);
    int y;
    sat = 1'b0;
`ifdef CAPTURE_ROUND_EN
    y = floor_div(x + STEP / 2, STEP);
    if (y > OMAX) begin y = OMAX; sat = 1'b1; end
    if (y < OMIN) begin y = OMIN; sat = 1'b1; end
`else
    y = floor_div(x, STEP);
`endif
    return y;
  endfunction

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; trig = 1'b0; din_valid = 1'b0;
    cfg_len = '0; cfg_decim = '0; din = '0;
  endtask

  // One capture: start at edge 0, inputs for edges 1..ncyc-1 generated and logged, then every
  // observed cycle compared against the model. din_sel: 0 ramp (64*i), 1 random, 2 constant.
  task automatic run_capture(input int len, input int decim, input int din_sel, input int din_const,
                             input int gap, input bit rnd_valid, input int trig_cycle,
                             input int restart_at, input int ncyc, input string name);
    bit v_log[256];
    bit t_log[256];
    int d_log[256];
    bit keep[256];
    int o_en[256], o_val[256], o_done[256], o_busy[256], o_sat[256];
    int last, nk, vi, exp_val;
    bit found, exp_sat, s;

    for (int i = 0; i < 256; i++) begin
      v_log[i] = 1'b0; t_log[i] = 1'b0; d_log[i] = 0; keep[i] = 1'b0;
    end

    start = 1'b1; cfg_len = CNT_W'(len); cfg_decim = DEC_W'(decim);
    din_valid = 1'b0; trig = 1'b0; din = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      o_en[c]   = int'(enable);
      o_val[c]  = int'($signed(signal_out));
      o_done[c] = int'(done);
      o_busy[c] = int'(busy);
      o_sat[c]  = int'(sat_flag);
      if (c + 1 < ncyc) begin
        start     = (c + 1 == restart_at);
        cfg_len   = CNT_W'(len + 3);
        cfg_decim = DEC_W'($urandom);
        if (gap > 0)        din_valid = ((c % (gap + 1)) == 0);
        else if (rnd_valid) din_valid = 1'($urandom_range(0, 1));
        else                din_valid = 1'b1;
        trig = (c + 1 >= trig_cycle);
        case (din_sel)
          0:       din = IN_W'(64 * (c + 1));
          1:       din = IN_W'($urandom);
          default: din = IN_W'(din_const);
        endcase
        v_log[c+1] = din_valid;
        t_log[c+1] = trig;
        d_log[c+1] = int'($signed(din));
      end else begin
        idle_inputs();
      end
    end

    // Which edges carry kept samples: trigger sample first, then every (decim+1)-th valid.
    if (len == 0) begin
      found = 1'b1; last = 0;
    end else begin
      found = 1'b0; nk = 0; vi = 0; last = ncyc + 10;
      for (int i = 1; i < ncyc; i++) begin
        if (!found && v_log[i] && t_log[i]) begin found = 1'b1; vi = 0; end
        if (found && v_log[i] && nk < len) begin
          if (vi % (decim + 1) == 0) begin
            keep[i] = 1'b1; nk++;
            if (nk == len) last = i;
          end
          vi++;
        end
      end
    end

    exp_val = last_out;
    exp_sat = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (keep[c]) begin
        exp_val = narrow_ref(d_log[c], s);
        if (s) exp_sat = 1'b1;
      end
      chk($sformatf("%s.enable@%0d", name, c), o_en[c], int'(keep[c]));
      chk($sformatf("%s.signal_out@%0d", name, c), o_val[c], exp_val);
      chk($sformatf("%s.done@%0d", name, c), o_done[c], int'(c == last + 1));
      chk($sformatf("%s.busy@%0d", name, c), o_busy[c], int'(len != 0 && c < last));
      chk($sformatf("%s.sat_flag@%0d", name, c), o_sat[c], int'(exp_sat));
    end
    last_out = exp_val;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.enable", int'(enable), 0);
    chk("reset.signal_out", int'(signal_out), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.sat_flag", int'(sat_flag), 0);
    rst = 1'b0;

    // Reset in the middle of a len=8 capture after three samples.
    @(posedge clk); #1;
    start = 1'b1; cfg_len = CNT_W'(8); cfg_decim = '0;
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b1; trig = 1'b1; din = IN_W'(64);
    @(posedge clk); #1;
    din = IN_W'(128);
    @(posedge clk); #1;
    din = IN_W'(192);
    @(posedge clk); #1;
    chk("midrst.enable_before", int'(enable), 1);
    chk("midrst.busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.enable", int'(enable), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.signal_out", int'(signal_out), 0);
    idle_inputs();
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst.after_done@%0d", k), int'(done), 0);
      chk($sformatf("midrst.after_busy@%0d", k), int'(busy), 0);
    end
    last_out = 0;
    run_capture(2, 0, 0, 0, 0, 1'b0, 1, -1, 8, "fresh");

    run_capture(4, 0, 0, 0, 0, 1'b0, 10, -1, 20, "ramp_len4");
    run_capture(3, 2, 0, 0, 0, 1'b0, 4, -1, 30, "decim2_cont");
    run_capture(3, 2, 0, 0, 5, 1'b0, 3, -1, 70, "decim2_gap");
    run_capture(0, 0, 1, 0, 0, 1'b0, 1, -1, 6, "len0");
    run_capture(2, 1, 1, 0, 0, 1'b0, 5, 2, 20, "restart_ignored");

    run_capture(1, 0, 2, 100, 0, 1'b0, 1, -1, 5, "narrow_p100");
    run_capture(1, 0, 2, -100, 0, 1'b0, 1, -1, 5, "narrow_m100");
    run_capture(1, 0, 2, 32767, 0, 1'b0, 1, -1, 5, "narrow_max");
    run_capture(1, 0, 2, -32768, 0, 1'b0, 1, -1, 5, "narrow_min");
    run_capture(1, 0, 2, 100, 0, 1'b0, 1, -1, 5, "sat_clear");

    for (int n = 0; n < 6; n++) begin
      run_capture(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1, 0, 0, 1'b1,
                  int'($urandom_range(1, 10)), -1, 120, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
